// File: rtl/fp_regfile_ctrl_pkg.sv
// Shared constants and FSM state type for the FP register file controller.
package fp_regfile_pkg;

  localparam int NREGS = 64;
  localparam int AW = $clog2(NREGS);
  localparam int DWIDTH = 64;
  localparam logic [DWIDTH-1:0] INIT_VALUE = '0;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    DBG_WAIT
  } state_e;

endpackage

// File: rtl/fp_regfile_ctrl_if.sv
// Bundle of FPU, debug and macro-side signals around the FP register file.
// The master drives requests and macro read data; the slave is the controller.
interface fp_regfile_ctrl_if #(
  parameter int AW = fp_regfile_pkg::AW,
  parameter int DWIDTH = fp_regfile_pkg::DWIDTH
);
  logic              busy;
  logic [AW-1:0]     fpu_r1_addr;
  logic [AW-1:0]     fpu_r2_addr;
  logic [AW-1:0]     fpu_r3_addr;
  logic              fpu_r3_en;
  logic              fpu_we;
  logic [AW-1:0]     fpu_waddr;
  logic [DWIDTH-1:0] fpu_wdata;
  logic [DWIDTH-1:0] fpu_d1;
  logic [DWIDTH-1:0] fpu_d2;
  logic [DWIDTH-1:0] fpu_d3;
  logic              dbg_req;
  logic              dbg_we;
  logic [AW-1:0]     dbg_addr;
  logic [DWIDTH-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DWIDTH-1:0] dbg_rdata;
  logic [AW-1:0]     rf_r1;
  logic [AW-1:0]     rf_r2;
  logic [AW-1:0]     rf_r3;
  logic [AW-1:0]     rf_rw;
  logic [DWIDTH-1:0] rf_dw;
  logic              rf_we;
  logic [DWIDTH-1:0] rf_d1;
  logic [DWIDTH-1:0] rf_d2;
  logic [DWIDTH-1:0] rf_d3;

  modport master (
    input  busy, fpu_d1, fpu_d2, fpu_d3, dbg_ack, dbg_rdata,
           rf_r1, rf_r2, rf_r3, rf_rw, rf_dw, rf_we,
    output fpu_r1_addr, fpu_r2_addr, fpu_r3_addr, fpu_r3_en,
           fpu_we, fpu_waddr, fpu_wdata,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
           rf_d1, rf_d2, rf_d3
  );

  modport slave (
    output busy, fpu_d1, fpu_d2, fpu_d3, dbg_ack, dbg_rdata,
           rf_r1, rf_r2, rf_r3, rf_rw, rf_dw, rf_we,
    input  fpu_r1_addr, fpu_r2_addr, fpu_r3_addr, fpu_r3_en,
           fpu_we, fpu_waddr, fpu_wdata,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
           rf_d1, rf_d2, rf_d3
  );
endinterface

// File: rtl/fp_regfile_ctrl_bypass.sv
// Write-to-read bypass for one macro read port: remembers whether the write
// issued alongside the read hit the same entry and substitutes that data.
module fp_rf_bypass #(
  parameter int AW = 6,
  parameter int DWIDTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  input  logic [DWIDTH-1:0] i_rdata,
  output logic [DWIDTH-1:0] o_data
);

  logic              r_hit;
  logic [DWIDTH-1:0] r_wdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit   <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_hit   <= i_we && (i_waddr == i_raddr);
      r_wdata <= i_wdata;
    end
  end

  // The macro returns pre-write data on a same-cycle collision; mask it here.
  assign o_data = r_hit ? r_wdata : i_rdata;

endmodule

// File: rtl/fp_regfile_ctrl.sv
// FP register file controller: post-reset zeroing sweep, FPU-priority write
// arbitration, debug access on the write port and read port 3, and bypass.
module fp_regfile_ctrl #(
  parameter int NREGS = fp_regfile_pkg::NREGS,
  parameter int DWIDTH = fp_regfile_pkg::DWIDTH,
  parameter logic [DWIDTH-1:0] INIT_VALUE = fp_regfile_pkg::INIT_VALUE
) (
  input  logic          clk,
  input  logic          rst,
  fp_regfile_ctrl_if.slave bus
);

  import fp_regfile_pkg::*;

  localparam int CNT_W = $clog2(NREGS);
  localparam logic [CNT_W-1:0] LAST_ENTRY = CNT_W'(NREGS - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_dbg_ack;
  logic              r_dbg_wr;

  logic              w_dbg_wr_gnt;
  logic              w_dbg_rd_gnt;
  logic              w_rf_we;
  logic [CNT_W-1:0]  w_rf_rw;
  logic [DWIDTH-1:0] w_rf_dw;
  logic [CNT_W-1:0]  w_rf_r3;
  logic [DWIDTH-1:0] w_d3;

  // Debug only gets the resource the FPU leaves free this cycle.
  assign w_dbg_wr_gnt = (r_state == IDLE) && bus.dbg_req && bus.dbg_we && !bus.fpu_we;
  assign w_dbg_rd_gnt = (r_state == IDLE) && bus.dbg_req && !bus.dbg_we && !bus.fpu_r3_en;

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_rf_we = 1'b0;
    w_rf_rw = bus.fpu_waddr;
    w_rf_dw = bus.fpu_wdata;
    if (r_state == INIT) begin
      w_rf_we = 1'b1;
      w_rf_rw = r_cnt;
      w_rf_dw = INIT_VALUE;
    end else if (bus.fpu_we) begin
      w_rf_we = 1'b1;
    end else if (w_dbg_wr_gnt) begin
      w_rf_we = 1'b1;
      w_rf_rw = bus.dbg_addr;
      w_rf_dw = bus.dbg_wdata;
    end
  end

  assign w_rf_r3 = w_dbg_rd_gnt ? bus.dbg_addr : bus.fpu_r3_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= INIT;
      r_cnt     <= '0;
      r_busy    <= 1'b1;
      r_dbg_ack <= 1'b0;
      r_dbg_wr  <= 1'b0;
    end else begin
      r_dbg_ack <= 1'b0;
      case (r_state)
        INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ENTRY) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (w_dbg_wr_gnt || w_dbg_rd_gnt) begin
            r_state   <= DBG_WAIT;
            r_dbg_ack <= 1'b1;
            r_dbg_wr  <= w_dbg_wr_gnt;
          end
        end
        DBG_WAIT: r_state <= IDLE;
        default: begin
          r_state <= INIT;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  fp_rf_bypass #(.AW(CNT_W), .DWIDTH(DWIDTH)) u_byp1 (
    .clk(clk), .rst(rst), .i_we(w_rf_we), .i_waddr(w_rf_rw), .i_wdata(w_rf_dw),
    .i_raddr(bus.fpu_r1_addr), .i_rdata(bus.rf_d1), .o_data(bus.fpu_d1)
  );

  fp_rf_bypass #(.AW(CNT_W), .DWIDTH(DWIDTH)) u_byp2 (
    .clk(clk), .rst(rst), .i_we(w_rf_we), .i_waddr(w_rf_rw), .i_wdata(w_rf_dw),
    .i_raddr(bus.fpu_r2_addr), .i_rdata(bus.rf_d2), .o_data(bus.fpu_d2)
  );

  fp_rf_bypass #(.AW(CNT_W), .DWIDTH(DWIDTH)) u_byp3 (
    .clk(clk), .rst(rst), .i_we(w_rf_we), .i_waddr(w_rf_rw), .i_wdata(w_rf_dw),
    .i_raddr(w_rf_r3), .i_rdata(bus.rf_d3), .o_data(w_d3)
  );

  assign bus.rf_r1     = bus.fpu_r1_addr;
  assign bus.rf_r2     = bus.fpu_r2_addr;
  assign bus.rf_r3     = w_rf_r3;
  assign bus.rf_we     = w_rf_we;
  assign bus.rf_rw     = w_rf_rw;
  assign bus.rf_dw     = w_rf_dw;
  assign bus.fpu_d3    = w_d3;
  assign bus.busy      = r_busy;
  assign bus.dbg_ack   = r_dbg_ack;
  assign bus.dbg_rdata = (r_dbg_ack && !r_dbg_wr) ? w_d3 : '0;

endmodule
